sysbus_arbiter: RTL and testbench
=================================

// Module: sysbus_arbiter
// PURPOSE
//  Shares one Sysbus Bottom port between two masters: client 0 (instruction fetch) and client 1 (data cache).
//  Sits between the two cache controllers and the top-level Sysbus; one transaction in flight at a time.
//  Round-robin grant, beat counting for BURST_LEN bursts, response routing to the granted client.
// PARAMETERS
//  DATA_WIDTH  64  width of req/resp beats
//  TAG_WIDTH   13  width of reqtag/resptag; bit TAG_WIDTH-1 is READ(1)/WRITE(0)
//  BURST_LEN   8   data beats per transfer (read response or write data); >=1
// PORTS
//  clk                 in   1           clock; all state updates on rising edge
//  reset               in   1           synchronous, active-high
//  c0_reqcyc/c1_reqcyc in   1           client beat valid; held until matching reqack
//  c0_req/c1_req       in   DATA_WIDTH  address beat, then write-data beats
//  c0_reqtag/c1_reqtag in   TAG_WIDTH   tag, sampled with the address beat
//  c0_reqack/c1_reqack out  1           beat accepted (bus_reqack passed to owner)
//  c0_resp/c1_resp     out  DATA_WIDTH  read beat (bus_resp to owner, else 0)
//  c0_resptag/c1_resptag out TAG_WIDTH  resp tag (to owner, else 0)
//  c0_respcyc/c1_respcyc out 1          read beat valid (to owner, else 0)
//  c0_respack/c1_respack in 1           client accepts read beat
//  bus_req             out  DATA_WIDTH  owner's c*_req in REQ/WDATA, else 0
//  bus_reqtag          out  TAG_WIDTH   owner's tag in REQ/WDATA, else 0
//  bus_reqcyc          out  1           owner's c*_reqcyc in REQ/WDATA, else 0
//  bus_reqack          in   1           bus accepted current beat
//  bus_resp/bus_resptag in  DATA_WIDTH/TAG_WIDTH  read beat from bus
//  bus_respcyc         in   1           read beat valid
//  bus_respack         out  1           owner's c*_respack in RWAIT, else 0
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, last_grant=1 (client 0 wins first), beat_cnt=0; all outputs 0.
//  Reset is honoured in any state; in-flight bus transaction abandoned, no further beats driven/acked.
//  States: IDLE, REQ (address beat), WDATA (write beats), RWAIT (read beats).
//  IDLE: if any c*_reqcyc, register owner; both requesting -> owner = !last_grant; next state REQ.
//   last_grant<=owner on grant. Outputs all 0 in IDLE (grant latency 1 cycle; bus_reqcyc first high in REQ).
//  REQ: bus_* = owner's req/reqtag/reqcyc; owner reqack = bus_reqack; beat_cnt=0.
//   bus_reqcyc & bus_reqack: tag bit READ -> RWAIT; WRITE -> WDATA.
//   Owner deasserts reqcyc before ack (protocol violation) -> IDLE, nothing counted.
//  WDATA: pass-through as in REQ; each cycle bus_reqcyc & bus_reqack increments beat_cnt.
//   Ack of beat BURST_LEN -> IDLE; writes get no response.
//  RWAIT: owner sees bus_resp/resptag/respcyc; bus_respack = owner respack.
//   Each bus_respcyc & respack cycle counts one beat; BURST_LEN-th beat -> IDLE.
//   Non-owner never sees respcyc=1; back-pressure (respack=0) holds count.
//  Outside RWAIT bus_respack=0: unsolicited responses never acked, never forwarded.
//  Non-owner client: reqack=0, respcyc=0, resp/resptag=0; its pending reqcyc is held off, not dropped.
//  Turnaround: final beat ack at cycle N -> IDLE at N+1 -> REQ (next owner) at N+2.
//  Simultaneous new request from owner during final beat: not granted until IDLE; round-robin then favours other client.
//  beat_cnt width $clog2(BURST_LEN)+1; never wraps (cleared in REQ).
// TESTING
//  Reset, c0 read addr 0x1000 tag READ, reqack at 2nd REQ cycle, 8 resp beats 0..7 -> c0 gets 0..7, returns IDLE, c1 outputs stay 0.
//  c0/c1 request same cycle after reset -> c0 granted; both again -> c1 granted; alternates (0,1,0,1).
//  c1 write addr 0x2000 + 8 data beats, bus_reqack every other cycle -> exactly 8 data beats forwarded, no respack, IDLE after 8th ack.
//  Read with c0_respack low 3 cycles at beat 4 -> bus_respack low same cycles, beat count holds, still 8 beats total.
//  bus_respcyc=1 while IDLE/WDATA -> bus_respack=0, no client respcyc.
//  reset asserted in RWAIT after 3 beats -> next cycle IDLE, all outputs 0; fresh c1 read completes normally.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Two-master Sysbus arbiter: round-robin grant of one Bottom port to client 0 (ifetch) and client 1 (dcache),
// one transaction in flight, burst beat counting and response routing back to the granted client.
module sysbus_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned TAG_WIDTH  = 13,
  parameter int unsigned BURST_LEN  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c0_reqcyc,
  input  logic [DATA_WIDTH-1:0] c0_req,
  input  logic [TAG_WIDTH-1:0]  c0_reqtag,
  output logic                  c0_reqack,
  output logic [DATA_WIDTH-1:0] c0_resp,
  output logic [TAG_WIDTH-1:0]  c0_resptag,
  output logic                  c0_respcyc,
  input  logic                  c0_respack,
  input  logic                  c1_reqcyc,
  input  logic [DATA_WIDTH-1:0] c1_req,
  input  logic [TAG_WIDTH-1:0]  c1_reqtag,
  output logic                  c1_reqack,
  output logic [DATA_WIDTH-1:0] c1_resp,
  output logic [TAG_WIDTH-1:0]  c1_resptag,
  output logic                  c1_respcyc,
  input  logic                  c1_respack,
  output logic [DATA_WIDTH-1:0] bus_req,
  output logic [TAG_WIDTH-1:0]  bus_reqtag,
  output logic                  bus_reqcyc,
  input  logic                  bus_reqack,
  input  logic [DATA_WIDTH-1:0] bus_resp,
  input  logic [TAG_WIDTH-1:0]  bus_resptag,
  input  logic                  bus_respcyc,
  output logic                  bus_respack
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WDATA = 2'd2,
    RWAIT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  // Owner-side view of the client request/response handshakes
  logic                  own_reqcyc;
  logic [DATA_WIDTH-1:0] own_req;
  logic [TAG_WIDTH-1:0]  own_reqtag;
  logic                  own_respack;
  logic                  last_beat;

  assign own_reqcyc  = owner_q ? c1_reqcyc  : c0_reqcyc;
  assign own_req     = owner_q ? c1_req     : c0_req;
  assign own_reqtag  = owner_q ? c1_reqtag  : c0_reqtag;
  assign own_respack = owner_q ? c1_respack : c0_respack;
  assign last_beat   = (beat_cnt_q == CNT_W'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    bus_req      = '0;
    bus_reqtag   = '0;
    bus_reqcyc   = 1'b0;
    bus_respack  = 1'b0;
    c0_reqack    = 1'b0;
    c1_reqack    = 1'b0;
    c0_resp      = '0;
    c1_resp      = '0;
    c0_resptag   = '0;
    c1_resptag   = '0;
    c0_respcyc   = 1'b0;
    c1_respcyc   = 1'b0;

    case (state_q)
      IDLE: begin
        if (c0_reqcyc || c1_reqcyc) begin
          owner_d      = (c0_reqcyc && c1_reqcyc) ? ~last_grant_q : c1_reqcyc;
          last_grant_d = owner_d;
          state_d      = REQ;
        end
      end

      REQ, WDATA: begin
        bus_req    = own_req;
        bus_reqtag = own_reqtag;
        bus_reqcyc = own_reqcyc;
        c0_reqack  = ~owner_q & bus_reqack;
        c1_reqack  = owner_q & bus_reqack;
        if (state_q == REQ) begin
          beat_cnt_d = '0;
          // An owner that drops reqcyc before the ack has given up the slot
          if (!own_reqcyc) begin
            state_d = IDLE;
          end else if (bus_reqack) begin
            state_d = own_reqtag[TAG_WIDTH-1] ? RWAIT : WDATA;
          end
        end else if (own_reqcyc && bus_reqack) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end

      RWAIT: begin
        bus_respack = own_respack;
        if (owner_q) begin
          c1_resp    = bus_resp;
          c1_resptag = bus_resptag;
          c1_respcyc = bus_respcyc;
        end else begin
          c0_resp    = bus_resp;
          c0_resptag = bus_resptag;
          c0_respcyc = bus_respcyc;
        end
        if (bus_respcyc && own_respack) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (last_beat) state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: inputs change 2ns after each rising edge, outputs checked 1ns later.
module tb_sysbus_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned TW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_reqcyc, c1_reqcyc;
  logic [DW-1:0] c0_req, c1_req;
  logic [TW-1:0] c0_reqtag, c1_reqtag;
  logic          c0_reqack, c1_reqack;
  logic [DW-1:0] c0_resp, c1_resp;
  logic [TW-1:0] c0_resptag, c1_resptag;
  logic          c0_respcyc, c1_respcyc;
  logic          c0_respack, c1_respack;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqcyc;
  logic          bus_reqack;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respcyc;
  logic          bus_respack;

  int checks   = 0;
  int failures = 0;

  sysbus_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .BURST_LEN(8)) dut (
    .clk(clk), .reset(reset),
    .c0_reqcyc(c0_reqcyc), .c0_req(c0_req), .c0_reqtag(c0_reqtag), .c0_reqack(c0_reqack),
    .c0_resp(c0_resp), .c0_resptag(c0_resptag), .c0_respcyc(c0_respcyc), .c0_respack(c0_respack),
    .c1_reqcyc(c1_reqcyc), .c1_req(c1_req), .c1_reqtag(c1_reqtag), .c1_reqack(c1_reqack),
    .c1_resp(c1_resp), .c1_resptag(c1_resptag), .c1_respcyc(c1_respcyc), .c1_respack(c1_respack),
    .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    c0_reqcyc = 0; c1_reqcyc = 0; c0_req = '0; c1_req = '0; c0_reqtag = '0; c1_reqtag = '0;
    c0_respack = 0; c1_respack = 0; bus_reqack = 0; bus_resp = '0; bus_resptag = '0; bus_respcyc = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  // Runs IDLE -> REQ -> ack; returns at the first RWAIT cycle with requests removed
  task automatic start_read(input bit cl, input logic [DW-1:0] addr, input logic [TW-1:0] tag);
    if (cl) begin c1_reqcyc = 1; c1_req = addr; c1_reqtag = tag; end
    else    begin c0_reqcyc = 1; c0_req = addr; c0_reqtag = tag; end
    step();
    bus_reqack = 1;
    step();
    clear_inputs();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1; bus_reqack = 1; bus_respcyc = 1; c0_respack = 1; c1_respack = 1;
    step();
    step();
    reset = 0;
    #1;
    checks++;
    if ({bus_req, bus_reqtag, bus_reqcyc, bus_respack, c0_reqack, c1_reqack, c0_respcyc, c1_respcyc,
         c0_resp, c1_resp, c0_resptag, c1_resptag} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: some output nonzero after reset (bus_respack=%b c0_respcyc=%b bus_reqcyc=%b)",
               bus_respack, c0_respcyc, bus_reqcyc);
    end
    clear_inputs();
  endtask

  task automatic test_read_c0();
    logic [TW-1:0] tag;
    tag = 13'h1005;
    do_reset();
    c0_reqcyc = 1; c0_req = 64'h1000; c0_reqtag = tag;
    #1;
    checks++;
    if (bus_reqcyc !== 1'b0) begin failures++; $display("FAIL rd_grant_latency: bus_reqcyc=%b exp 0", bus_reqcyc); end
    step();
    #1;
    checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag, c0_reqack} !== {1'b1, 64'h1000, tag, 1'b0}) begin
      failures++;
      $display("FAIL rd_req_1st: cyc=%b req=%h tag=%h ack=%b exp 1 1000 %h 0", bus_reqcyc, bus_req, bus_reqtag, c0_reqack, tag);
    end
    step();
    bus_reqack = 1;
    #1;
    checks++;
    if (c0_reqack !== 1'b1 || c1_reqack !== 1'b0) begin
      failures++; $display("FAIL rd_reqack: c0=%b c1=%b exp 1 0", c0_reqack, c1_reqack);
    end
    step();
    clear_inputs();
    c0_respack = 1;
    for (int i = 0; i < 8; i++) begin
      bus_respcyc = 1; bus_resp = DW'(i); bus_resptag = tag;
      #1;
      checks++;
      if ({c0_respcyc, c0_resp, c0_resptag, bus_respack} !== {1'b1, DW'(i), tag, 1'b1} ||
          {c1_respcyc, c1_resp, c1_resptag} !== '0) begin
        failures++;
        $display("FAIL rd_beat%0d: c0cyc=%b c0resp=%h bus_respack=%b c1cyc=%b c1resp=%h exp 1 %h 1 0 0",
                 i, c0_respcyc, c0_resp, bus_respack, c1_respcyc, c1_resp, i);
      end
      step();
    end
    // Stray beat after the 8th: must be ignored in IDLE
    #1;
    checks++;
    if (bus_respack !== 1'b0 || c0_respcyc !== 1'b0) begin
      failures++; $display("FAIL rd_back_to_idle: bus_respack=%b c0_respcyc=%b exp 0 0", bus_respack, c0_respcyc);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic exp_owner;
    do_reset();
    for (int r = 0; r < 4; r++) begin
      exp_owner = 1'(r % 2);
      c0_reqcyc = 1; c0_req = 64'h100; c0_reqtag = 13'h0a00;
      c1_reqcyc = 1; c1_req = 64'h200; c1_reqtag = 13'h0b00;
      step();
      #1;
      checks++;
      if (bus_req !== (exp_owner ? 64'h200 : 64'h100) || bus_reqtag !== (exp_owner ? 13'h0b00 : 13'h0a00)) begin
        failures++;
        $display("FAIL rr_round%0d: bus_req=%h bus_reqtag=%h exp owner c%0d", r, bus_req, bus_reqtag, exp_owner);
      end
      // Owner withdraws before ack; arbiter must drop back to IDLE
      c0_reqcyc = 0; c1_reqcyc = 0;
      step();
    end
    clear_inputs();
  endtask

  task automatic test_write_c1();
    int k;
    clear_inputs();
    c1_reqcyc = 1; c1_req = 64'h2000; c1_reqtag = 13'h0007;
    step();
    bus_reqack = 1;
    #1;
    checks++;
    if ({bus_reqcyc, bus_req, c1_reqack, c0_reqack} !== {1'b1, 64'h2000, 1'b1, 1'b0}) begin
      failures++; $display("FAIL wr_addr: cyc=%b req=%h c1ack=%b c0ack=%b exp 1 2000 1 0", bus_reqcyc, bus_req, c1_reqack, c0_reqack);
    end
    step();
    k = 0;
    for (int j = 0; j < 16 && k < 8; j++) begin
      c1_req = 64'hD0 + DW'(k); bus_reqack = 1'(j % 2); bus_respcyc = 1; c1_respack = 1;
      #1;
      checks++;
      if ({bus_reqcyc, bus_req, c1_reqack, bus_respack, c1_respcyc} !== {1'b1, 64'hD0 + DW'(k), bus_reqack, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL wr_cycle%0d: cyc=%b req=%h c1ack=%b respack=%b c1respcyc=%b exp 1 %h %b 0 0",
                 j, bus_reqcyc, bus_req, c1_reqack, bus_respack, c1_respcyc, 64'hD0 + DW'(k), bus_reqack);
      end
      if (bus_reqack) k++;
      step();
    end
    checks++;
    if (k !== 8) begin failures++; $display("FAIL wr_beat_count: got %0d exp 8", k); end
    // Turnaround: IDLE here despite a held request, REQ one cycle later
    c1_req = 64'h2100; bus_reqack = 1;
    #1;
    checks++;
    if (bus_reqcyc !== 1'b0 || c1_reqack !== 1'b0) begin
      failures++; $display("FAIL wr_idle_after_8: bus_reqcyc=%b c1_reqack=%b exp 0 0", bus_reqcyc, c1_reqack);
    end
    step();
    bus_reqack = 0;
    #1;
    checks++;
    if (bus_reqcyc !== 1'b1 || bus_req !== 64'h2100) begin
      failures++; $display("FAIL wr_turnaround: bus_reqcyc=%b bus_req=%h exp 1 2100", bus_reqcyc, bus_req);
    end
    c1_reqcyc = 0;
    step();
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int k;
    int stall;
    logic ack;
    start_read(1'b0, 64'h3000, 13'h1003);
    k = 0; stall = 0;
    for (int j = 0; j < 16 && k < 8; j++) begin
      ack = !(k == 4 && stall < 3);
      bus_respcyc = 1; bus_resp = 64'hB0 + DW'(k); c0_respack = ack;
      #1;
      checks++;
      if ({bus_respack, c0_respcyc, c0_resp} !== {ack, 1'b1, 64'hB0 + DW'(k)}) begin
        failures++;
        $display("FAIL bp_cycle%0d: bus_respack=%b c0_respcyc=%b c0_resp=%h exp %b 1 %h",
                 j, bus_respack, c0_respcyc, c0_resp, ack, 64'hB0 + DW'(k));
      end
      if (ack) k++; else stall++;
      step();
    end
    c0_respack = 1; bus_respcyc = 1;
    #1;
    checks++;
    if (bus_respack !== 1'b0 || c0_respcyc !== 1'b0 || stall !== 3) begin
      failures++; $display("FAIL bp_end: bus_respack=%b c0_respcyc=%b stalls=%0d exp 0 0 3", bus_respack, c0_respcyc, stall);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_midread();
    start_read(1'b0, 64'h5000, 13'h1001);
    c0_respack = 1;
    for (int i = 0; i < 3; i++) begin
      bus_respcyc = 1; bus_resp = DW'(i);
      step();
    end
    reset = 1;
    step();
    reset = 0;
    bus_respcyc = 1; c0_respack = 1;
    #1;
    checks++;
    if ({bus_respack, c0_respcyc, c0_resp, bus_reqcyc} !== '0) begin
      failures++; $display("FAIL mid_reset: bus_respack=%b c0_respcyc=%b c0_resp=%h exp 0 0 0", bus_respack, c0_respcyc, c0_resp);
    end
    clear_inputs();
    start_read(1'b1, 64'h4000, 13'h1004);
    c1_respack = 1;
    for (int i = 0; i < 8; i++) begin
      bus_respcyc = 1; bus_resp = 64'h40 + DW'(i); bus_resptag = 13'h1004;
      #1;
      checks++;
      if ({c1_respcyc, c1_resp, c1_resptag, bus_respack, c0_respcyc} !== {1'b1, 64'h40 + DW'(i), 13'h1004, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL c1_rd_beat%0d: c1cyc=%b c1resp=%h respack=%b c0cyc=%b exp 1 %h 1 0",
                 i, c1_respcyc, c1_resp, bus_respack, c0_respcyc, 64'h40 + DW'(i));
      end
      step();
    end
    #1;
    checks++;
    if (bus_respack !== 1'b0 || c1_respcyc !== 1'b0) begin
      failures++; $display("FAIL c1_rd_idle: bus_respack=%b c1_respcyc=%b exp 0 0", bus_respack, c1_respcyc);
    end
    step();
    clear_inputs();
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    step();
    test_reset();
    test_read_c0();
    test_round_robin();
    test_write_c1();
    test_backpressure();
    test_reset_midread();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
